// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: control/target inputs and fetch address of the fetch stage.
// INSTR_FETCH_STALL_EN adds stall_in.
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH     = 16,
    parameter int TARGET_WIDTH = 8
);
    logic [TARGET_WIDTH-1:0] dst_in;
    logic                    br_ctrl;
    logic                    jmp_ctrl;
    logic                    accdata_in;
    logic [PC_WIDTH-1:0]     instr_addr;
`ifdef INSTR_FETCH_STALL_EN
    logic                    stall_in;
    modport master (output dst_in, br_ctrl, jmp_ctrl, accdata_in, stall_in, input instr_addr);
    modport slave  (input dst_in, br_ctrl, jmp_ctrl, accdata_in, stall_in, output instr_addr);
`else
    modport master (output dst_in, br_ctrl, jmp_ctrl, accdata_in, input instr_addr);
    modport slave  (input dst_in, br_ctrl, jmp_ctrl, accdata_in, output instr_addr);
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register plus +1 incrementor; next PC is PC+1 or an in-page target.
// INSTR_FETCH_STALL_EN adds a stall input that freezes the PC.
module instr_fetch_pc_incr #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_y
);
    assign o_y = i_a + 1'b1;
endmodule

module instr_fetch_pc_reg #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         reset_ctrl,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Power-up value lets an unreset run start fetching at address 0.
    logic [W-1:0] r_q = '0;
    always_ff @(posedge CLK or posedge reset_ctrl)
        if (reset_ctrl) r_q <= '0;
        else if (i_en) r_q <= i_d;
    assign o_q = r_q;
endmodule

module instr_fetch_unit #(
    parameter int PC_WIDTH     = 16,
    parameter int TARGET_WIDTH = 8
) (
    input logic               CLK,
    input logic               reset_ctrl,
    instr_fetch_unit_if.slave bus
);
    logic [PC_WIDTH-1:0] w_pc;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_br;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_acc_ok;
    logic                w_take;
    logic                w_en;

    instr_fetch_pc_incr #(.W(PC_WIDTH)) u_inc (.i_a(w_pc), .o_y(w_pc_inc));

    // Page comes from PC+1 so a branch sitting at xxFF lands in the next page.
    assign w_pc_br   = {w_pc_inc[PC_WIDTH-1:TARGET_WIDTH], bus.dst_in};
    assign w_acc_ok  = (bus.accdata_in === 1'b1);
    assign w_take    = (bus.br_ctrl & w_acc_ok) | bus.jmp_ctrl;
    assign w_pc_next = w_take ? w_pc_br : w_pc_inc;
`ifdef INSTR_FETCH_STALL_EN
    assign w_en = ~bus.stall_in;
`else
    assign w_en = 1'b1;
`endif

    instr_fetch_pc_reg #(.W(PC_WIDTH)) u_pc (
        .CLK       (CLK),
        .reset_ctrl(reset_ctrl),
        .i_en      (w_en),
        .i_d       (w_pc_next),
        .o_q       (w_pc)
    );

    assign bus.instr_addr = w_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of the fetch-stage PC sequencing.
module tb_instr_fetch_unit;
    logic CLK;
    logic reset_ctrl;
    int   errors = 0;
    int   checks = 0;

    instr_fetch_unit_if #(.PC_WIDTH(16), .TARGET_WIDTH(8)) bus ();
    instr_fetch_unit #(.PC_WIDTH(16), .TARGET_WIDTH(8)) dut (
        .CLK       (CLK),
        .reset_ctrl(reset_ctrl),
        .bus       (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_free_run();
        #1;
        checks++;
        if (bus.instr_addr !== 16'h0000) begin errors++; $display("FAIL time_zero: got %h expected 0000", bus.instr_addr); end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.instr_addr !== 16'(i)) begin errors++; $display("FAIL free_run[%0d]: got %h expected %h", i, bus.instr_addr, 16'(i)); end
        end
    endtask

    task automatic test_branch_taken();
        bus.br_ctrl = 1'b1; bus.accdata_in = 1'b1; bus.dst_in = 8'h00;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0000) begin errors++; $display("FAIL br_taken: got %h expected 0000", bus.instr_addr); end
        bus.br_ctrl = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (bus.instr_addr !== 16'(i)) begin errors++; $display("FAIL br_after[%0d]: got %h expected %h", i, bus.instr_addr, 16'(i)); end
        end
    endtask

    task automatic test_not_taken();
        bus.jmp_ctrl = 1'b1; bus.dst_in = 8'h10;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0010) begin errors++; $display("FAIL jmp_0010: got %h expected 0010", bus.instr_addr); end
        bus.jmp_ctrl = 1'b0; bus.br_ctrl = 1'b1; bus.accdata_in = 1'b0; bus.dst_in = 8'h80;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0011) begin errors++; $display("FAIL br_acc0: got %h expected 0011", bus.instr_addr); end
        bus.br_ctrl = 1'b0; bus.jmp_ctrl = 1'b1; bus.dst_in = 8'h10;
        step();
        bus.jmp_ctrl = 1'b0; bus.br_ctrl = 1'b1; bus.accdata_in = 1'bx; bus.dst_in = 8'h80;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0011) begin errors++; $display("FAIL br_accx: got %h expected 0011", bus.instr_addr); end
        bus.jmp_ctrl = 1'b1; bus.accdata_in = 1'b1; bus.dst_in = 8'h33;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0033) begin errors++; $display("FAIL br_and_jmp: got %h expected 0033", bus.instr_addr); end
        bus.br_ctrl = 1'b0; bus.jmp_ctrl = 1'b0; bus.accdata_in = 1'b0;
    endtask

    task automatic test_jump_carry();
        bus.jmp_ctrl = 1'b1; bus.dst_in = 8'hFF;
        step();
        checks++;
        if (bus.instr_addr !== 16'h00FF) begin errors++; $display("FAIL jmp_00ff: got %h expected 00ff", bus.instr_addr); end
        bus.dst_in = 8'h20;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0120) begin errors++; $display("FAIL jmp_page_carry: got %h expected 0120", bus.instr_addr); end
    endtask

    task automatic test_wrap();
        int n;
        bus.jmp_ctrl = 1'b1; bus.dst_in = 8'hFF;
        n = 0;
        do begin step(); n++; end while (bus.instr_addr !== 16'hFFFF && n < 300);
        checks++;
        if (bus.instr_addr !== 16'hFFFF || n != 255) begin errors++; $display("FAIL climb_ffff: got %h after %0d edges expected ffff after 255", bus.instr_addr, n); end
        bus.jmp_ctrl = 1'b0;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0000) begin errors++; $display("FAIL wrap: got %h expected 0000", bus.instr_addr); end
    endtask

    task automatic test_async_reset();
        bus.jmp_ctrl = 1'b1; bus.dst_in = 8'h42;
        step();
        bus.jmp_ctrl = 1'b0;
        checks++;
        if (bus.instr_addr !== 16'h0042) begin errors++; $display("FAIL jmp_0042: got %h expected 0042", bus.instr_addr); end
        #2 reset_ctrl = 1'b1;
        #1;
        checks++;
        if (bus.instr_addr !== 16'h0000) begin errors++; $display("FAIL async_reset: got %h expected 0000", bus.instr_addr); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.instr_addr !== 16'h0000) begin errors++; $display("FAIL reset_hold[%0d]: got %h expected 0000", i, bus.instr_addr); end
        end
        reset_ctrl = 1'b0;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0001) begin errors++; $display("FAIL reset_release: got %h expected 0001", bus.instr_addr); end
    endtask

    task automatic test_branch_page();
        bus.jmp_ctrl = 1'b1; bus.dst_in = 8'hFF;
        step();
        bus.jmp_ctrl = 1'b0; bus.br_ctrl = 1'b1; bus.accdata_in = 1'b1; bus.dst_in = 8'h44;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0144) begin errors++; $display("FAIL br_page: got %h expected 0144", bus.instr_addr); end
        bus.br_ctrl = 1'b0; bus.accdata_in = 1'b0;
    endtask

`ifdef INSTR_FETCH_STALL_EN
    task automatic test_stall();
        reset_ctrl = 1'b1;
        #1 reset_ctrl = 1'b0;
        bus.jmp_ctrl = 1'b1; bus.dst_in = 8'h07;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0007) begin errors++; $display("FAIL stall_setup: got %h expected 0007", bus.instr_addr); end
        bus.stall_in = 1'b1; bus.dst_in = 8'h05;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.instr_addr !== 16'h0007) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected 0007", i, bus.instr_addr); end
        end
        bus.stall_in = 1'b0;
        step();
        checks++;
        if (bus.instr_addr !== 16'h0005) begin errors++; $display("FAIL stall_release: got %h expected 0005", bus.instr_addr); end
        bus.jmp_ctrl = 1'b0;
    endtask
`endif

    initial begin
        reset_ctrl     = 1'b0;
        bus.dst_in     = 8'h00;
        bus.br_ctrl    = 1'b0;
        bus.jmp_ctrl   = 1'b0;
        bus.accdata_in = 1'b0;
`ifdef INSTR_FETCH_STALL_EN
        bus.stall_in   = 1'b0;
`endif
        test_free_run();
        test_branch_taken();
        test_not_taken();
        test_jump_carry();
        test_wrap();
        test_async_reset();
        test_branch_page();
`ifdef INSTR_FETCH_STALL_EN
        test_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
